dual_issue_scoreboard: RTL and testbench
========================================

DUAL_ISSUE_SCOREBOARD -- requirements
Module: dual_issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (x0 hardwired zero).
REQ-002 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports instr1_valid / instr2_valid  input  1  decode lane holds an instruction.
REQ-006 SHALL have ports instrN_rs1_address, instrN_rs2_address, instrN_rd_address  input  5  source/dest registers per lane (N=1,2).
REQ-007 SHALL have ports instrN_rd_we  input  1  lane writes rd.
REQ-008 SHALL have ports wbN_WE  input  1, wbN_rd_address  input  5  writeback ports driving the register file write lanes (N=1,2).
REQ-009 SHALL have ports instr1_issue / instr2_issue  output  1  lane issues this cycle.
REQ-010 SHALL have port busy  output  NREG  registered pending-write vector.
REQ-011 SHALL have port stall_cycles  output  CNT_W  saturating count of lane-1 stall cycles.
REQ-012 SHALL have port wb_error  output  1  sticky flag, writeback to non-busy register.

Function
REQ-013 SHALL treat register 0 as never busy; busy[0] constant 0; rd=0 never sets busy; rs=0 never hazards.
REQ-014 SHALL compute hazard1 = busy[rs1] | busy[rs2] | (rd_we & rd!=0 & busy[rd]) for lane 1 from registered busy only (no same-cycle writeback bypass).
REQ-015 SHALL drive instr1_issue = instr1_valid & ~hazard1, combinationally, same cycle.
REQ-016 SHALL compute hazard2 for lane 2 as REQ-014 on its own fields.
REQ-017 SHALL block lane 2 on intra-pair RAW: instr1_rd_we & instr1_rd!=0 & (instr2_rs1==instr1_rd | instr2_rs2==instr1_rd).
REQ-018 SHALL block lane 2 on intra-pair WAW: both rd_we, both rd nonzero and equal.
REQ-019 SHALL drive instr2_issue = instr2_valid & instr1_issue & ~hazard2 & ~pair RAW & ~pair WAW (strict in-order; lane 2 never issues alone).
REQ-020 SHALL set busy[rd] at next edge for each issued lane with rd_we & rd!=0.
REQ-021 SHALL clear busy[addr] at next edge for each wbN_WE with addr!=0.
REQ-022 SHALL give set priority over clear when both target the same register in one cycle.
REQ-023 SHALL, when wb1 and wb2 target the same busy register in one cycle, clear it once without error.
REQ-024 SHALL set wb_error at next edge when wbN_WE, addr!=0 and busy[addr]==0; flag holds until reset.
REQ-025 SHALL increment stall_cycles at each edge where instr1_valid & ~instr1_issue; saturate at all-ones.
REQ-026 SHALL not count lane-2-only blocking in stall_cycles.

Reset
REQ-027 SHALL, while rst_n low, clear busy, stall_cycles, wb_error to 0 immediately.
REQ-028 SHALL force instr1_issue and instr2_issue to 0 while rst_n low.
REQ-029 SHALL resume normal operation on first rising edge after rst_n deasserts; reset mid-stream discards all pending state.

Verification
REQ-030 SHALL verify independent pair: lane1 rd=5, lane2 rs1=6 rd=7, all idle -> both issue; next cycle busy=0x000000A0.
REQ-031 SHALL verify RAW stall: busy[5]=1, lane1 rs1=5 -> issue1=0, issue2=0, stall_cycles+1 per cycle; wb1_WE rd=5 -> issue1=1 the cycle after clear, not same cycle.
REQ-032 SHALL verify intra-pair RAW/WAW: lane1 rd=3, lane2 rs2=3 (then lane2 rd=3) -> issue1=1, issue2=0; busy[3]=1 only.
REQ-033 SHALL verify x0: lane1 rd=0 rd_we=1, lane2 rs1=0 -> both issue, busy stays 0; wb1_WE addr=0 -> wb_error stays 0.
REQ-034 SHALL verify boundaries: wb2_WE to non-busy reg 9 -> wb_error=1 sticky; same-cycle issue rd=4 and wb clear 4 -> busy[4]=1; force 65535 stalls -> stall_cycles holds 0xFFFF.
REQ-035 SHALL verify async reset: assert rst_n=0 mid-cycle with busy=0xFFFFFFFE -> busy=0, issue outputs 0 before next edge.

Source files
------------

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue register scoreboard: tracks pending writes, decides which of two
// in-order decode lanes may issue, counts lane-1 stalls and flags writebacks
// to registers that had no write pending.
module dual_issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr1_valid,
  input  logic [4:0]       instr1_rs1_address,
  input  logic [4:0]       instr1_rs2_address,
  input  logic [4:0]       instr1_rd_address,
  input  logic             instr1_rd_we,
  input  logic             instr2_valid,
  input  logic [4:0]       instr2_rs1_address,
  input  logic [4:0]       instr2_rs2_address,
  input  logic [4:0]       instr2_rd_address,
  input  logic             instr2_rd_we,
  input  logic             wb1_WE,
  input  logic [4:0]       wb1_rd_address,
  input  logic             wb2_WE,
  input  logic [4:0]       wb2_rd_address,
  output logic             instr1_issue,
  output logic             instr2_issue,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wb_error
);

  // Registers addressable through a 5-bit field; anything beyond NREG reads idle.
  localparam int NV = (NREG < 32) ? NREG : 32;

  logic [31:0]     busy_view;
  logic            hazard1;
  logic            hazard2;
  logic            pair_raw;
  logic            pair_waw;
  logic            wb_bad;
  logic [NREG-1:0] busy_next;

  // 32-entry view of the busy vector so any 5-bit address can be looked up; x0 is never busy.
  always_comb begin
    busy_view = '0;
    for (int i = 1; i < NV; i++) begin
      busy_view[i] = busy[i];
    end
  end

  // Hazards use registered busy only, so a writeback frees a register one cycle later.
  always_comb begin
    hazard1  = busy_view[instr1_rs1_address] | busy_view[instr1_rs2_address] |
               (instr1_rd_we & (instr1_rd_address != 5'd0) & busy_view[instr1_rd_address]);
    hazard2  = busy_view[instr2_rs1_address] | busy_view[instr2_rs2_address] |
               (instr2_rd_we & (instr2_rd_address != 5'd0) & busy_view[instr2_rd_address]);
    pair_raw = instr1_rd_we & (instr1_rd_address != 5'd0) &
               ((instr2_rs1_address == instr1_rd_address) |
                (instr2_rs2_address == instr1_rd_address));
    pair_waw = instr1_rd_we & instr2_rd_we & (instr1_rd_address != 5'd0) &
               (instr1_rd_address == instr2_rd_address);
  end

  assign instr1_issue = rst_n & instr1_valid & ~hazard1;
  assign instr2_issue = rst_n & instr2_valid & instr1_issue & ~hazard2 & ~pair_raw & ~pair_waw;

  // Next busy vector: writebacks clear first, then issues set so a set wins on a collision.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < NV; i++) begin
      if (wb1_WE && (wb1_rd_address == 5'(i))) busy_next[i] = 1'b0;
      if (wb2_WE && (wb2_rd_address == 5'(i))) busy_next[i] = 1'b0;
      if (instr1_issue && instr1_rd_we && (instr1_rd_address == 5'(i))) busy_next[i] = 1'b1;
      if (instr2_issue && instr2_rd_we && (instr2_rd_address == 5'(i))) busy_next[i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // A writeback is erroneous when it targets a nonzero register with no pending write.
  always_comb begin
    wb_bad = (wb1_WE & (wb1_rd_address != 5'd0) & ~busy_view[wb1_rd_address]) |
             (wb2_WE & (wb2_rd_address != 5'd0) & ~busy_view[wb2_rd_address]);
  end

  // State registers: busy vector, sticky error flag and saturating lane-1 stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      stall_cycles <= '0;
      wb_error     <= 1'b0;
    end else begin
      busy <= busy_next;
      if (wb_bad) wb_error <= 1'b1;
      if (instr1_valid && !instr1_issue && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Scoreboard bench for dual_issue_scoreboard: the stimulus process predicts
// each cycle's outputs from a register-level model and queues them; a monitor
// on the falling edge pops and compares.
module tb_dual_issue_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       instr1_valid, instr1_rd_we, instr2_valid, instr2_rd_we;
  logic [4:0] instr1_rs1_address, instr1_rs2_address, instr1_rd_address;
  logic [4:0] instr2_rs1_address, instr2_rs2_address, instr2_rd_address;
  logic       wb1_WE, wb2_WE;
  logic [4:0] wb1_rd_address, wb2_rd_address;
  logic       instr1_issue, instr2_issue;
  logic [31:0] busy;
  logic [15:0] stall_cycles;
  logic       wb_error;

  typedef struct packed {
    logic        i1;
    logic        i2;
    logic [31:0] busy;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: which registers await a write, stall count, error flag
  bit          m_busy[32];
  int unsigned m_stall;
  bit          m_err;

  dual_issue_scoreboard #(.NREG(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr1_valid(instr1_valid), .instr1_rs1_address(instr1_rs1_address),
    .instr1_rs2_address(instr1_rs2_address), .instr1_rd_address(instr1_rd_address),
    .instr1_rd_we(instr1_rd_we),
    .instr2_valid(instr2_valid), .instr2_rs1_address(instr2_rs1_address),
    .instr2_rs2_address(instr2_rs2_address), .instr2_rd_address(instr2_rd_address),
    .instr2_rd_we(instr2_rd_we),
    .wb1_WE(wb1_WE), .wb1_rd_address(wb1_rd_address),
    .wb2_WE(wb2_WE), .wb2_rd_address(wb2_rd_address),
    .instr1_issue(instr1_issue), .instr2_issue(instr2_issue),
    .busy(busy), .stall_cycles(stall_cycles), .wb_error(wb_error)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit pending(input logic [4:0] a);
    return (a != 5'd0) && m_busy[a];
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    for (int i = 1; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then advance the model to the next edge
  task automatic apply_stimulus();
    exp_t e;
    bit h1, h2, raw, waw, go1, go2;
    e = '0;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(e);
      return;
    end
    h1  = pending(instr1_rs1_address) || pending(instr1_rs2_address) ||
          (instr1_rd_we && pending(instr1_rd_address));
    h2  = pending(instr2_rs1_address) || pending(instr2_rs2_address) ||
          (instr2_rd_we && pending(instr2_rd_address));
    raw = instr1_rd_we && instr1_rd_address != 0 &&
          (instr2_rs1_address == instr1_rd_address || instr2_rs2_address == instr1_rd_address);
    waw = instr1_rd_we && instr2_rd_we && instr1_rd_address != 0 &&
          instr1_rd_address == instr2_rd_address;
    go1 = instr1_valid && !h1;
    go2 = instr2_valid && go1 && !h2 && !raw && !waw;
    e.i1    = go1;
    e.i2    = go2;
    e.busy  = model_word();
    e.stall = m_stall[15:0];
    e.err   = m_err;
    exp_q.push_back(e);
    if (wb1_WE && wb1_rd_address != 0 && !m_busy[wb1_rd_address]) m_err = 1;
    if (wb2_WE && wb2_rd_address != 0 && !m_busy[wb2_rd_address]) m_err = 1;
    if (wb1_WE) m_busy[wb1_rd_address] = 0;
    if (wb2_WE) m_busy[wb2_rd_address] = 0;
    if (go1 && instr1_rd_we) m_busy[instr1_rd_address] = 1;
    if (go2 && instr2_rd_we) m_busy[instr2_rd_address] = 1;
    m_busy[0] = 0;
    if (instr1_valid && !go1 && m_stall < 65535) m_stall++;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every queued prediction on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("instr1_issue", {31'b0, instr1_issue}, {31'b0, mon_e.i1});
      check_output("instr2_issue", {31'b0, instr2_issue}, {31'b0, mon_e.i2});
      check_output("busy", busy, mon_e.busy);
      check_output("stall_cycles", {16'b0, stall_cycles}, {16'b0, mon_e.stall});
      check_output("wb_error", {31'b0, wb_error}, {31'b0, mon_e.err});
    end
  end

  task automatic set_idle();
    instr1_valid = 0; instr1_rs1_address = 0; instr1_rs2_address = 0;
    instr1_rd_address = 0; instr1_rd_we = 0;
    instr2_valid = 0; instr2_rs1_address = 0; instr2_rs2_address = 0;
    instr2_rd_address = 0; instr2_rd_we = 0;
    wb1_WE = 0; wb1_rd_address = 0; wb2_WE = 0; wb2_rd_address = 0;
  endtask

  // One cycle of stimulus: lane 1, lane 2, then both writeback ports
  task automatic step(input logic v1, input logic [4:0] a1, input logic [4:0] b1,
                      input logic [4:0] d1, input logic w1,
                      input logic v2, input logic [4:0] a2, input logic [4:0] b2,
                      input logic [4:0] d2, input logic w2,
                      input logic we1, input logic [4:0] wa1,
                      input logic we2, input logic [4:0] wa2);
    @(posedge clk); #1;
    instr1_valid = v1; instr1_rs1_address = a1; instr1_rs2_address = b1;
    instr1_rd_address = d1; instr1_rd_we = w1;
    instr2_valid = v2; instr2_rs1_address = a2; instr2_rs2_address = b2;
    instr2_rd_address = d2; instr2_rd_we = w2;
    wb1_WE = we1; wb1_rd_address = wa1; wb2_WE = we2; wb2_rd_address = wa2;
    apply_stimulus();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted just after an edge, held across one edge, released mid-cycle with idle inputs
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    apply_stimulus();
    @(posedge clk); #1;
    apply_stimulus();
    @(negedge clk); #1;
    set_idle();
    rst_n = 1;
  endtask

  initial begin
    logic [4:0] r1, r2;
    bit         e1, e2;
    rst_n = 0;
    set_idle();
    model_reset();
    do_reset();

    // Independent pair, then idle to observe busy = 0xA0
    step(1, 0, 0, 5, 1, 1, 6, 0, 7, 1, 0, 0, 0, 0);
    idle_step();

    // RAW stall on busy[5]; writeback frees it only for the following cycle
    step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5, 1, 7);
    step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Intra-pair RAW, then intra-pair WAW on register 3
    step(1, 0, 0, 3, 1, 1, 0, 3, 8, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(1, 0, 0, 3, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);

    // x0 never busy, never hazards, writeback to x0 is not an error
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    idle_step();

    // Both writeback ports clearing the same busy register together
    step(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 12);
    idle_step();

    // Random traffic over a small register window so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      r1 = 5'($urandom_range(1, 7));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(1, 7));
      e1 = m_busy[r1] && ($urandom_range(0, 1) == 1);
      e2 = m_busy[r2] && ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           e1, r1, e2, r2);
    end

    do_reset();

    // Writeback to idle register 9 sets a sticky error
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle_step();
    idle_step();

    // Issue to 4 while a writeback clears 4 in the same cycle: set wins
    step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    idle_step();

    // Saturate the stall counter by holding lane 1 on busy[5]
    step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 65540; n++) step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 4);
    idle_step();

    // Fill registers 1..31, then reset mid-cycle with issuable inputs present
    for (int k = 0; k < 15; k++) begin
      step(1, 0, 0, 5'(2 * k + 1), 1, 1, 0, 0, 5'(2 * k + 2), 1, 0, 0, 0, 0);
    end
    step(1, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle_step();

    // Drain the scoreboard within a bounded number of cycles
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
